fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage RV32I pipeline; it produces the instruction word and PC that the decode stage consumes. It owns the program counter and issues single-outstanding read requests to a variable-latency instruction memory. It holds a one-entry buffer for responses that arrive while decode is stalled, and discards stale responses after a taken branch or jump. Its outputs form the F/D pipeline register.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- StallF_i  input  1  hazard stall. Decode cannot accept; the F/D register holds.
- FlushD_i  input  1  the F/D register loads a bubble.
- PCSrcE_i  input  1  taken branch or jump resolved in execute; redirect.
- PCTargetE_i  input  32  redirect target.
- imem_req_o  output  1  read request, valid for one cycle, always accepted.
- imem_addr_o  output  32  request byte address.
- imem_rdata_i  input  32  response data.
- imem_valid_i  input  1  response valid. Responses return in order, at least 1 cycle after the request.
- InstrD_o  output  32  instruction to decode.
- PCD_o  output  32  PC of InstrD_o.
- PCPlus4D_o  output  32  PCD_o + 4.
- ValidD_o  output  1  InstrD_o is a real instruction (0 = bubble).

## Operation
- Registers: PCF (32), FSM state, buffer (32) plus buffer-full flag, and F/D register (InstrD, PCD, PCPlus4D, ValidD).
- FSM states:
  - FETCH: no request outstanding.
  - WAIT: request for PCF outstanding.
  - DROP: stale request outstanding.
  - HOLD: response held in the buffer.
- FETCH:
  - If PCSrcE_i: PCF<=PCTargetE_i, no request, stay in FETCH.
  - Otherwise: imem_req_o=1, imem_addr_o=PCF, go to WAIT.
- WAIT, no imem_valid_i:
  - If PCSrcE_i: PCF<=PCTargetE_i, go to DROP.
  - Otherwise stay in WAIT.
- WAIT, imem_valid_i:
  - If PCSrcE_i: discard the response, PCF<=PCTargetE_i, go to FETCH.
  - Else if StallF_i: buffer<=imem_rdata_i, go to HOLD.
  - Else deliver to F/D (InstrD<=rdata, PCD<=PCF, PCPlus4D<=PCF+4, ValidD<=1) and PCF<=PCF+4. In the same cycle, imem_req_o=1 with imem_addr_o=PCF+4; stay in WAIT (back-to-back issue).
- DROP:
  - A further PCSrcE_i updates PCF and stays in DROP.
  - On imem_valid_i the data is discarded and the state goes to FETCH.
- HOLD:
  - If PCSrcE_i: clear the buffer, PCF<=PCTargetE_i, go to FETCH.
  - Else if !StallF_i: deliver the buffer to F/D with PCD=PCF, PCF<=PCF+4, go to FETCH.
- imem_valid_i is ignored in FETCH and HOLD; the memory must not produce it there.
- F/D register update priority:
  1. rst.
  2. FlushD_i: InstrD<=NOP_INSTR, ValidD<=0; PCD and PCPlus4D hold.
  3. StallF_i: hold all fields.
  4. A delivery loads the instruction.
  5. Otherwise load a bubble (NOP_INSTR, ValidD=0; PCD and PCPlus4D hold).
- FlushD_i affects only the F/D register; PCF and FSM follow PCSrcE_i alone.
- PC arithmetic is modulo 2^32; PCF=32'hFFFF_FFFC wraps to 0. Address bits [1:0] pass through unchecked.

## Timing
- Reset values:
  - State FETCH, PCF=RESET_PC, buffer empty.
  - InstrD_o=NOP_INSTR, PCD_o=0, PCPlus4D_o=0, ValidD_o=0.
  - imem_req_o=0 while rst is high.
- First request (addr RESET_PC) is issued in the first cycle after rst deasserts.
- imem_req_o and imem_addr_o are combinational from state, PCF, imem_valid_i, StallF_i and PCSrcE_i.
- Latency: request in cycle N, response in cycle N+k (k≥1); InstrD_o is visible in cycle N+k+1 if not stalled.
- Throughput: with k=1 and no stalls, one instruction per cycle after the first.
- At most one request is outstanding. No request is issued in DROP or HOLD, or in any cycle with PCSrcE_i=1.
- Simultaneous events:
  - Response plus PCSrcE_i: the redirect wins.
  - StallF_i plus FlushD_i: the flush wins for F/D.
  - Response plus StallF_i: the response goes to the buffer.
- Reset mid-operation discards any outstanding request. The memory is reset on the same rst.

## Test plan
- **Reset and stream:** deassert rst with a k=1 memory returning addr+0x100. Required:
  - Requests to 0x0, 0x4, 0x8 on consecutive cycles.
  - InstrD_o shows 0x100, 0x104, 0x108 from cycle 2.
  - PCD_o=0x0, 0x4, 0x8, with ValidD_o=1.
- **Stall capture:** k=3; StallF_i=1 in the response cycle for PC 0x8, held 2 cycles. Required:
  - No new request is issued.
  - The F/D register holds PCD=0x4.
  - After release, InstrD_o=0x108 and PCD_o=0x8; the next request is to 0xC.
- **Redirect while waiting:** k=3; PCSrcE_i=1 with target 0x40 one cycle after the request to 0x8. Required:
  - The response for 0x8 is discarded.
  - The next request is to 0x40.
  - ValidD_o=0 until 0x140 arrives with PCD_o=0x40.
- **Redirect coincident with response:** k=1; PCSrcE_i=1 with target 0x80 in a response cycle. Required:
  - The response is discarded and imem_req_o=0 that cycle.
  - The next request is to 0x80.
- **Flush vs stall:** assert FlushD_i and StallF_i together. Required: InstrD_o=0x0000_0013 and ValidD_o=0 next cycle, with PCD_o unchanged.
- **Wrap and reset mid-flight:** PC 0xFFFF_FFFC. Required:
  - The next request after 0xFFFF_FFFC is to 0x0.
  - Asserting rst in WAIT gives all outputs at reset values next cycle.
  - The first request after reset is to RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with PC, one outstanding imem read,
// a one-entry response buffer for decode stalls, and the F/D register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF_i,
  input  logic        FlushD_i,
  input  logic        PCSrcE_i,
  input  logic [31:0] PCTargetE_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_valid_i,
  output logic [31:0] InstrD_o,
  output logic [31:0] PCD_o,
  output logic [31:0] PCPlus4D_o,
  output logic        ValidD_o
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DROP,
    S_HOLD
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pcf;
  logic [31:0] w_pcf_nxt;
  logic [31:0] w_pcf_plus4;
  logic [31:0] r_buf;
  logic [31:0] w_buf_nxt;
  logic        r_buf_full;
  logic        w_buf_full_nxt;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_deliver;
  logic [31:0] w_deliver_instr;

  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc4_d;
  logic        r_valid_d;

  assign w_pcf_plus4 = r_pcf + 32'd4;

  always_comb begin
    w_state_nxt     = r_state;
    w_pcf_nxt       = r_pcf;
    w_buf_nxt       = r_buf;
    w_buf_full_nxt  = r_buf_full;
    w_req           = 1'b0;
    w_addr          = r_pcf;
    w_deliver       = 1'b0;
    w_deliver_instr = imem_rdata_i;
    unique case (r_state)
      S_FETCH: begin
        if (PCSrcE_i) begin
          w_pcf_nxt = PCTargetE_i;
        end else begin
          w_req       = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!imem_valid_i) begin
          if (PCSrcE_i) begin
            w_pcf_nxt   = PCTargetE_i;
            w_state_nxt = S_DROP;
          end
        end else if (PCSrcE_i) begin
          w_pcf_nxt   = PCTargetE_i;
          w_state_nxt = S_FETCH;
        end else if (StallF_i) begin
          w_buf_nxt      = imem_rdata_i;
          w_buf_full_nxt = 1'b1;
          w_state_nxt    = S_HOLD;
        end else begin
          // deliver and issue the next sequential fetch in the same cycle
          w_deliver = 1'b1;
          w_pcf_nxt = w_pcf_plus4;
          w_req     = 1'b1;
          w_addr    = w_pcf_plus4;
        end
      end
      S_DROP: begin
        if (PCSrcE_i) begin
          w_pcf_nxt = PCTargetE_i;
        end
        if (imem_valid_i) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_HOLD: begin
        if (PCSrcE_i) begin
          w_buf_full_nxt = 1'b0;
          w_pcf_nxt      = PCTargetE_i;
          w_state_nxt    = S_FETCH;
        end else if (!StallF_i && r_buf_full) begin
          w_deliver       = 1'b1;
          w_deliver_instr = r_buf;
          w_buf_full_nxt  = 1'b0;
          w_pcf_nxt       = w_pcf_plus4;
          w_state_nxt     = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  assign imem_req_o  = w_req && !rst;
  assign imem_addr_o = w_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_pcf      <= RESET_PC;
      r_buf      <= 32'd0;
      r_buf_full <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pcf      <= w_pcf_nxt;
      r_buf      <= w_buf_nxt;
      r_buf_full <= w_buf_full_nxt;
    end
  end

  // flush beats stall; a cycle with nothing to deliver loads a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= 32'd0;
      r_pc4_d   <= 32'd0;
      r_valid_d <= 1'b0;
    end else if (FlushD_i) begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end else if (StallF_i) begin
      r_instr_d <= r_instr_d;
    end else if (w_deliver) begin
      r_instr_d <= w_deliver_instr;
      r_pc_d    <= r_pcf;
      r_pc4_d   <= w_pcf_plus4;
      r_valid_d <= 1'b1;
    end else begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end
  end

  assign InstrD_o   = r_instr_d;
  assign PCD_o      = r_pc_d;
  assign PCPlus4D_o = r_pc4_d;
  assign ValidD_o   = r_valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios with a variable-latency memory model;
// expected requests, deliveries and register snapshots are cycle-stamped.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        StallF_i;
  logic        FlushD_i;
  logic        PCSrcE_i;
  logic [31:0] PCTargetE_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        imem_valid_i;
  logic [31:0] InstrD_o;
  logic [31:0] PCD_o;
  logic [31:0] PCPlus4D_o;
  logic        ValidD_o;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .StallF_i     (StallF_i),
    .FlushD_i     (FlushD_i),
    .PCSrcE_i     (PCSrcE_i),
    .PCTargetE_i  (PCTargetE_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .imem_valid_i (imem_valid_i),
    .InstrD_o     (InstrD_o),
    .PCD_o        (PCD_o),
    .PCPlus4D_o   (PCPlus4D_o),
    .ValidD_o     (ValidD_o)
  );

  typedef struct {
    int          cyc;
    logic [31:0] d;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        v;
  } exp_t;

  exp_t exp_req[$];
  exp_t exp_fd[$];
  exp_t exp_snap[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int k       = 1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // memory: response k cycles after the request, data = addr + 0x100
  bit          m_pend;
  int          m_wait;
  logic [31:0] m_addr;
  bit          p_req;
  bit          p_valid;
  bit          p_rst;
  logic [31:0] p_addr;

  initial begin
    imem_valid_i = 1'b0;
    imem_rdata_i = 32'hDEAD_BEEF;
    m_pend = 0; m_wait = 0; m_addr = 0;
    p_req = 0; p_valid = 0; p_rst = 1; p_addr = 0;
    forever begin
      @(negedge clk);
      if (p_rst) begin
        m_pend = 0;
      end else begin
        if (p_valid) m_pend = 0;
        if (p_req) begin
          m_pend = 1;
          m_wait = k;
          m_addr = p_addr;
        end
      end
      if (m_pend) begin
        m_wait--;
        imem_valid_i = (m_wait == 0);
      end else begin
        imem_valid_i = 1'b0;
      end
      imem_rdata_i = imem_valid_i ? m_addr + 32'h100 : 32'hDEAD_BEEF;
      #2;
      p_req   = imem_req_o;
      p_addr  = imem_addr_o;
      p_valid = imem_valid_i;
      p_rst   = rst;
    end
  end

  task automatic push_req(input int c, input logic [31:0] a);
    exp_t e;
    e.cyc = c; e.d = a; e.pc = 0; e.pc4 = 0; e.v = 1;
    exp_req.push_back(e);
  endtask

  task automatic push_fd(input int c, input logic [31:0] d,
                         input logic [31:0] pc);
    exp_t e;
    e.cyc = c; e.d = d; e.pc = pc; e.pc4 = pc + 32'd4; e.v = 1;
    exp_fd.push_back(e);
  endtask

  task automatic push_snap(input int c, input logic [31:0] d,
                           input logic [31:0] pc, input logic [31:0] pc4,
                           input logic v);
    exp_t e;
    e.cyc = c; e.d = d; e.pc = pc; e.pc4 = pc4; e.v = v;
    exp_snap.push_back(e);
  endtask

  task automatic cmp_req(input exp_t e);
    n_tests++;
    if (cyc != e.cyc || imem_addr_o !== e.d) begin
      n_fail++;
      $display("FAIL req: got cyc=%0d addr=%h, want cyc=%0d addr=%h",
               cyc, imem_addr_o, e.cyc, e.d);
    end
  endtask

  task automatic cmp_fd(input string nm, input exp_t e);
    n_tests++;
    if (cyc != e.cyc || InstrD_o !== e.d || PCD_o !== e.pc ||
        PCPlus4D_o !== e.pc4 || ValidD_o !== e.v) begin
      n_fail++;
      $display("FAIL %s: got cyc=%0d %h %h %h v=%b, want cyc=%0d %h %h %h v=%b",
               nm, cyc, InstrD_o, PCD_o, PCPlus4D_o, ValidD_o,
               e.cyc, e.d, e.pc, e.pc4, e.v);
    end
  endtask

  task automatic unexp(input string nm, input logic [31:0] got);
    n_tests++;
    n_fail++;
    $display("FAIL %s_unexpected: got cyc=%0d val=%h, want none",
             nm, cyc, got);
  endtask

  // monitor samples late in each cycle, after stimulus has settled
  bit stall_prev = 0;
  initial forever begin
    exp_t e;
    @(negedge clk);
    #3;
    if (imem_req_o === 1'b1) begin
      if (exp_req.size() == 0) unexp("req", imem_addr_o);
      else begin
        e = exp_req.pop_front();
        cmp_req(e);
      end
    end
    if (ValidD_o === 1'b1 && !stall_prev) begin
      if (exp_fd.size() == 0) unexp("fd", InstrD_o);
      else begin
        e = exp_fd.pop_front();
        cmp_fd("fd", e);
      end
    end
    if (exp_snap.size() != 0 && exp_snap[0].cyc == cyc) begin
      e = exp_snap.pop_front();
      cmp_fd("snap", e);
    end
    stall_prev = StallF_i;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got cyc=%0d, want finish", cyc);
    $fatal(1, "timeout");
  end

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset(input int n, input bit snap, output int c0);
    rst = 1'b1;
    StallF_i = 1'b0;
    FlushD_i = 1'b0;
    PCSrcE_i = 1'b0;
    if (snap) push_snap(cyc + 1, NOP, 32'd0, 32'd0, 1'b0);
    repeat (n) @(negedge clk);
    rst = 1'b0;
    c0 = cyc;
  endtask

  task automatic drain(input string nm, input int left);
    n_tests++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d pending, want 0", nm, left);
    end
  endtask

  initial begin
    int c0;
    int c1;
    rst = 1'b1;
    StallF_i = 1'b0;
    FlushD_i = 1'b0;
    PCSrcE_i = 1'b0;
    PCTargetE_i = 32'd0;
    @(negedge clk);

    // reset and k=1 stream
    k = 1;
    do_reset(3, 1, c0);
    for (int i = 0; i < 5; i++) push_req(c0 + i, 32'(4 * i));
    for (int i = 0; i < 4; i++)
      push_fd(c0 + 2 + i, 32'h100 + 32'(4 * i), 32'(4 * i));
    at(c0 + 5);

    // stall capture, k=3
    k = 3;
    do_reset(2, 0, c0);
    push_req(c0, 32'h0);
    push_req(c0 + 3, 32'h4);
    push_req(c0 + 6, 32'h8);
    push_req(c0 + 12, 32'hC);
    push_req(c0 + 15, 32'h10);
    push_fd(c0 + 4, 32'h100, 32'h0);
    push_fd(c0 + 7, 32'h104, 32'h4);
    push_fd(c0 + 12, 32'h108, 32'h8);
    push_fd(c0 + 16, 32'h10C, 32'hC);
    push_snap(c0 + 10, NOP, 32'h4, 32'h8, 1'b0);
    push_snap(c0 + 11, NOP, 32'h4, 32'h8, 1'b0);
    at(c0 + 9);
    StallF_i = 1'b1;
    at(c0 + 11);
    StallF_i = 1'b0;
    at(c0 + 17);

    // redirect while waiting, k=3
    do_reset(2, 0, c0);
    push_req(c0, 32'h0);
    push_req(c0 + 3, 32'h4);
    push_req(c0 + 6, 32'h8);
    push_req(c0 + 10, 32'h40);
    push_req(c0 + 13, 32'h44);
    push_fd(c0 + 4, 32'h100, 32'h0);
    push_fd(c0 + 7, 32'h104, 32'h4);
    push_fd(c0 + 14, 32'h140, 32'h40);
    at(c0 + 7);
    PCSrcE_i = 1'b1;
    PCTargetE_i = 32'h40;
    at(c0 + 8);
    PCSrcE_i = 1'b0;
    at(c0 + 15);

    // redirect coincident with response, k=1
    k = 1;
    do_reset(2, 0, c0);
    push_req(c0, 32'h0);
    push_req(c0 + 1, 32'h4);
    push_req(c0 + 3, 32'h80);
    push_req(c0 + 4, 32'h84);
    push_req(c0 + 5, 32'h88);
    push_fd(c0 + 2, 32'h100, 32'h0);
    push_fd(c0 + 5, 32'h180, 32'h80);
    push_fd(c0 + 6, 32'h184, 32'h84);
    at(c0 + 2);
    PCSrcE_i = 1'b1;
    PCTargetE_i = 32'h80;
    at(c0 + 3);
    PCSrcE_i = 1'b0;
    at(c0 + 6);

    // flush and stall together, k=1
    do_reset(2, 0, c0);
    for (int i = 0; i < 4; i++) push_req(c0 + i, 32'(4 * i));
    push_req(c0 + 6, 32'h10);
    push_req(c0 + 7, 32'h14);
    push_req(c0 + 8, 32'h18);
    push_fd(c0 + 2, 32'h100, 32'h0);
    push_fd(c0 + 3, 32'h104, 32'h4);
    push_fd(c0 + 4, 32'h108, 32'h8);
    push_fd(c0 + 6, 32'h10C, 32'hC);
    push_fd(c0 + 8, 32'h110, 32'h10);
    push_fd(c0 + 9, 32'h114, 32'h14);
    push_snap(c0 + 5, NOP, 32'h8, 32'hC, 1'b0);
    at(c0 + 4);
    StallF_i = 1'b1;
    FlushD_i = 1'b1;
    at(c0 + 5);
    StallF_i = 1'b0;
    FlushD_i = 1'b0;
    at(c0 + 9);

    // PC wrap, then reset while waiting, k=2
    k = 2;
    do_reset(2, 0, c0);
    PCSrcE_i = 1'b1;
    PCTargetE_i = 32'hFFFF_FFFC;
    push_req(c0 + 1, 32'hFFFF_FFFC);
    push_req(c0 + 3, 32'h0);
    push_fd(c0 + 4, 32'h0000_00FC, 32'hFFFF_FFFC);
    at(c0 + 1);
    PCSrcE_i = 1'b0;
    at(c0 + 4);
    do_reset(2, 1, c1);
    push_req(c1, 32'h0);
    push_req(c1 + 2, 32'h4);
    push_fd(c1 + 3, 32'h100, 32'h0);
    at(c1 + 4);
    rst = 1'b1;
    at(c1 + 7);

    drain("req", exp_req.size());
    drain("fd", exp_fd.size());
    drain("snap", exp_snap.size());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
